// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier operand sequencer.
// The offsets give the data-bus timing relative to the mul_start cycle.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int MUL_A_OFFSET = 1;
    localparam int MUL_B_OFFSET = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLoadA,
        StLoadB,
        StWait,
        StHold
    } state_e;

endpackage

// File: rtl/mul_operand_sequencer_if.sv
// Operand, multiplier and result handshake signals of the sequencer.
// master is the sequencer's view; slave is the view of its environment.
interface mul_operand_sequencer_if #(
    parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             mul_start;
    logic [WIDTH-1:0] mul_data;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_product;
    logic             res_err;

    modport master (
        input  in_valid, in_a, in_b, mul_done, mul_product, res_ready,
        output in_ready, mul_start, mul_data, res_valid, res_product, res_err
    );

    modport slave (
        output in_valid, in_a, in_b, mul_done, mul_product, res_ready,
        input  in_ready, mul_start, mul_data, res_valid, res_product, res_err
    );

endinterface

// File: rtl/mul_operand_sequencer.sv
// Feeds operand pairs to the multiplier over its shared data bus, waits for done with a
// timeout, and holds the captured product on a valid/ready result port.
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH   = MUL_WIDTH,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mul_operand_sequencer_if.master bus,
    output logic                   busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_product_q, res_product_d;
    logic             res_err_q, res_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ra_q          <= '0;
            rb_q          <= '0;
            cnt_q         <= '0;
            res_product_q <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            cnt_q         <= cnt_d;
            res_product_q <= res_product_d;
            res_err_q     <= res_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        cnt_d         = cnt_q;
        res_product_d = res_product_q;
        res_err_d     = res_err_q;
        bus.in_ready  = 1'b0;
        bus.mul_start = 1'b0;
        bus.mul_data  = '0;
        bus.res_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A still-high done means the multiplier has not returned to idle yet.
                bus.in_ready = !bus.mul_done;
                if (bus.in_valid && !bus.mul_done) begin
                    ra_d    = bus.in_a;
                    rb_d    = bus.in_b;
                    state_d = StStart;
                end
            end
            StStart: begin
                bus.mul_start = 1'b1;
                bus.mul_data  = ra_q;
                state_d       = StLoadA;
            end
            StLoadA: begin
                bus.mul_data = ra_q;
                state_d      = StLoadB;
            end
            StLoadB: begin
                bus.mul_data = rb_q;
                cnt_d        = '0;
                state_d      = StWait;
            end
            StWait: begin
                bus.mul_data = rb_q;
                cnt_d        = cnt_q + TW'(1);
                // Done is checked first so a same-cycle timeout still returns the product.
                if (bus.mul_done) begin
                    res_product_d = bus.mul_product;
                    res_err_d     = 1'b0;
                    state_d       = StHold;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    res_product_d = '0;
                    res_err_d     = 1'b1;
                    state_d       = StHold;
                end
            end
            StHold: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.res_product = res_product_q;
    assign bus.res_err     = res_err_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Sits directly upstream of the 16-bit multiplier top and also captures the multiplier's result.
- Accepts operand pairs (A, B) on a valid/ready handshake.
- Drives the multiplier's start and shared data_in bus in the required cycle order, then waits for done with a timeout.
- Presents the product downstream on a valid/ready handshake, holding it until accepted.

Parameters:
- WIDTH, 16, operand, data-bus and product width.
- TIMEOUT, 1024, max cycles in WAIT before aborting with an error; must be ≥ 2.
- TW, $clog2(TIMEOUT+1), timeout counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- mul_start  out  1  start strobe to multiplier
- mul_data  out  WIDTH  multiplier data_in bus
- mul_done  in  1  multiplier done, level
- mul_product  in  WIDTH  multiplier product
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_product  out  WIDTH  captured product
- res_err  out  1  result is a timeout abort, qualified by res_valid
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; all outputs 0 except in_ready; counter cleared.
  - in_ready=1 only if mul_done=0 (combinational from state and mul_done).
  - Reset mid-operation abandons the operation silently; no result is emitted.
- Multiplier contract:
  - mul_start is high for exactly one cycle (cycle T).
  - The multiplier samples A from mul_data at the edge ending cycle T+1 and B at the edge ending cycle T+2.
  - mul_done rises some cycles later and holds the product valid while high.
- FSM states: IDLE, START, LOAD_A, LOAD_B, WAIT, HOLD.
- IDLE:
  - in_ready = !mul_done.
  - On in_valid && in_ready: latch in_a→ra and in_b→rb, go to START.
  - While mul_done=1 (multiplier not yet idle), no pair is accepted.
- START: mul_start=1, mul_data=ra; next state LOAD_A.
- LOAD_A: mul_data=ra; next state LOAD_B.
- LOAD_B: mul_data=rb; clear the counter; next state WAIT.
- WAIT:
  - mul_data=rb; counter increments each cycle.
  - If mul_done=1: res_product←mul_product, res_err←0, go to HOLD.
  - Else if counter==TIMEOUT-1: res_product←0, res_err←1, go to HOLD.
  - If mul_done rises on the same cycle the timeout is reached, done wins (err=0).
- HOLD:
  - res_valid=1; res_product and res_err stable.
  - On res_ready: go to IDLE, res_valid drops the next cycle.
  - res_ready is ignored outside HOLD.
- mul_data: 0 in IDLE and HOLD.
- Throughput: one operation at a time.
  - Minimum latency from accept to res_valid is 4 cycles plus the multiplier's done delay.
  - in_ready is low from START through HOLD.
- Width rules:
  - The product is truncated to WIDTH by the multiplier.
  - The sequencer performs no arithmetic and no overflow detection.
  - Operands are passed unmodified; A or B = 0 is legal. A hang from such operands is covered by the timeout.

Decomposition:
- Shared package mul_pkg holds:
  - state enum typedef (IDLE..HOLD, 3 bits);
  - localparam WIDTH default;
  - localparam MUL_A_OFFSET=1 and MUL_B_OFFSET=2 (data-bus timing relative to start).
- No sub-module is needed beyond an optional timeout_counter (TW-bit, clear/enable/terminal-count). Instantiate it if the team's counter library already has one; otherwise keep it inline.

Test Plan:
- Basic: in_a=25, in_b=4, model done after 30 cycles with product 100.
  - mul_start is a one-cycle pulse.
  - mul_data=25 on cycles T and T+1, and 4 on cycle T+2.
  - res_valid with res_product=100 and res_err=0.
- Backpressure: res_ready held low 10 cycles after res_valid.
  - res_product is held at 100; in_ready stays 0.
  - Accept occurs on the first res_ready cycle; IDLE follows.
- Timeout: TIMEOUT=16, model never asserts done.
  - res_valid with res_err=1 and res_product=0 exactly 16 cycles after entering WAIT.
- Done/timeout tie: done asserted on the cycle the counter reaches TIMEOUT-1 → res_err=0 and the real product is captured.
- Sticky done: model holds mul_done=1 after a result is accepted → in_ready=0, and no mul_start until done drops; then a queued pair (7, 9) yields 63.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT.
  - Next cycle: state IDLE, res_valid=0, busy=0, in_ready=1.
  - No spurious result afterward.
